// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// UART transmitter with an internal transmit FIFO. Bytes are accepted on a
// valid/ready handshake, queued, and serialised LSB first as
// start / DATA_BITS data / optional parity / one or two stop bits.
// Parity mode, stop-bit count and bit divisor are sampled once per frame,
// when the frame's byte is popped, so they may change freely between frames.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous active-low reset
//   din_i         byte to transmit (only the low DATA_BITS bits are sent)
//   din_valid_i   push request
//   din_ready_o   FIFO not full; a push happens on din_valid_i && din_ready_o
//   tx_en_i       when low no new frame starts; a frame in flight completes
//   parity_i      000 none, 001 odd, 010 even, 100 zero, 101 one, else none
//   stopbits_i    0 = one stop bit, 1 = two stop bits
//   divisor_i     clock cycles per bit; 0 behaves as 1
//   tx_o          serial line, idle high
//   busy_o        a frame is in progress
//   fifo_count_o  current FIFO occupancy
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    din_i,
    input  logic                          din_valid_i,
    output logic                          din_ready_o,
    input  logic                          tx_en_i,
    input  logic [2:0]                    parity_i,
    input  logic                          stopbits_i,
    input  logic [DIV_WIDTH-1:0]          divisor_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int                   AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]           DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]           IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [AW:0]          PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO: pointers carry one extra MSB so full and empty differ
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic        has_data_q;
    logic [7:0]  fifo_head;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // No bypass: a full FIFO refuses a push even when a pop happens alongside.
    assign push        = din_valid_i && !fifo_full;
    assign din_ready_o = !fifo_full;
    assign fifo_count_o = wr_ptr_q - rd_ptr_q;
    assign fifo_head   = fifo_mem[rd_ptr_q[AW-1:0]];

    // NOTE: storage carries no reset; the pointers alone define which entries
    // are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= din_i & DATA_MASK;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            has_data_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            // Registered occupancy flag: a freshly written entry becomes
            // eligible for transmission one cycle after it lands.
            has_data_q <= !fifo_empty;
        end
    end

    // ------------------------------------------------------------------
    // Frame serialiser
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 frame_end;
    logic                 start_ok;

    // The fifo_empty term keeps a stale has_data_q from popping an empty FIFO.
    assign start_ok = tx_en_i && has_data_q && !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            div_q     <= DIV_ONE;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        frame_end = 1'b0;

        if (state_q == S_IDLE) begin
            frame_end = 1'b1;
        end else if (timer_q != '0) begin
            timer_d = timer_q - DIV_ONE;
        end else begin
            timer_d = div_q - DIV_ONE;
            unique case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
                S_DATA: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
                S_STOP1: begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                        tx_d    = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                S_STOP2: frame_end = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end

        // Idle or end of frame: start the next frame directly when allowed,
        // latching the configuration it will use for its whole duration.
        if (frame_end) begin
            if (start_ok) begin
                pop      = 1'b1;
                state_d  = S_START;
                tx_d     = 1'b0;
                shift_d  = fifo_head;
                idx_d    = '0;
                stop2_d  = stopbits_i;
                div_d    = (divisor_i == '0) ? DIV_ONE : divisor_i;
                timer_d  = div_d - DIV_ONE;
                unique case (parity_i)
                    3'b001:  begin par_en_d = 1'b1; par_bit_d = ~^fifo_head; end
                    3'b010:  begin par_en_d = 1'b1; par_bit_d = ^fifo_head;  end
                    3'b100:  begin par_en_d = 1'b1; par_bit_d = 1'b0;        end
                    3'b101:  begin par_en_d = 1'b1; par_bit_d = 1'b1;        end
                    default: begin par_en_d = 1'b0; par_bit_d = 1'b0;        end
                endcase
            end else begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine. A second instance with DATA_BITS=7
// shares clock, reset and configuration but has its own push strobe.
module tb_uart_tx_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  din_i;
    logic        din_valid_i;
    logic        din_valid7;
    logic        tx_en_i;
    logic [2:0]  parity_i;
    logic        stopbits_i;
    logic [23:0] divisor_i;

    logic        din_ready_o, tx_o, busy_o;
    logic [4:0]  fifo_count_o;
    logic        ready7, tx7, busy7;
    logic [4:0]  count7;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_engine #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(24)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .din_i        (din_i),
        .din_valid_i  (din_valid_i),
        .din_ready_o  (din_ready_o),
        .tx_en_i      (tx_en_i),
        .parity_i     (parity_i),
        .stopbits_i   (stopbits_i),
        .divisor_i    (divisor_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    uart_tx_engine #(.DATA_BITS(7), .FIFO_DEPTH(16), .DIV_WIDTH(24)) dut7 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .din_i        (din_i),
        .din_valid_i  (din_valid7),
        .din_ready_o  (ready7),
        .tx_en_i      (tx_en_i),
        .parity_i     (parity_i),
        .stopbits_i   (stopbits_i),
        .divisor_i    (divisor_i),
        .tx_o         (tx7),
        .busy_o       (busy7),
        .fifo_count_o (count7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] d);
        din_i = d;
        din_valid_i = 1'b1;
        @(negedge clk_i);
        din_valid_i = 1'b0;
    endtask

    task automatic push7(input logic [7:0] d);
        din_i = d;
        din_valid7 = 1'b1;
        @(negedge clk_i);
        din_valid7 = 1'b0;
    endtask

    // Wait (bounded) for the start bit of the selected instance.
    task automatic wait_start(input string tag, input bit sel7);
        int n = 0;
        while (((sel7 ? tx7 : tx_o) !== 1'b0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 32'(sel7 ? tx7 : tx_o), 32'(0));
    endtask

    // Called on the first sample of the start bit; returns on the first
    // sample after the frame. par < 0 means no parity bit.
    task automatic expect_frame(input string tag, input logic [7:0] data, input int nbits,
                                input int par, input int nstop, input int div, input bit sel7);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (par >= 0) bits.push_back(par[0]);
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        check({tag, "_busy"}, 32'(sel7 ? busy7 : busy_o), 32'(1));
        for (int k = 0; k < bits.size(); k++) begin
            for (int d = 0; d < div; d++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, k, d),
                      32'(sel7 ? tx7 : tx_o), 32'(bits[k]));
                @(negedge clk_i);
            end
        end
    endtask

    initial begin
        int lows;
        rst_i       = 1'b0;
        din_i       = 8'h00;
        din_valid_i = 1'b0;
        din_valid7  = 1'b0;
        tx_en_i     = 1'b1;
        parity_i    = 3'b000;
        stopbits_i  = 1'b0;
        divisor_i   = 24'd1;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_tx",    32'(tx_o),         32'(1));
        check("rst_busy",  32'(busy_o),       32'(0));
        check("rst_count", 32'(fifo_count_o), 32'(0));
        check("rst_ready", 32'(din_ready_o),  32'(1));
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // 0x3A, odd parity, one stop, divisor 4; start bit on 2nd edge after push
        parity_i = 3'b001; stopbits_i = 1'b0; divisor_i = 24'd4;
        push(8'h3A);
        check("t1_tx_p0",    32'(tx_o),         32'(1));
        check("t1_count_p0", 32'(fifo_count_o), 32'(1));
        @(negedge clk_i);
        check("t1_tx_p1",    32'(tx_o),         32'(1));
        @(negedge clk_i);
        check("t1_tx_p2",    32'(tx_o),         32'(0));
        check("t1_count_p2", 32'(fifo_count_o), 32'(0));
        expect_frame("t1", 8'h3A, 8, 1, 1, 4, 1'b0);
        check("t1_busy_end", 32'(busy_o), 32'(0));
        check("t1_tx_end",   32'(tx_o),   32'(1));

        // 0x55, 0xAA back to back, no parity, two stops, divisor 1
        parity_i = 3'b000; stopbits_i = 1'b1; divisor_i = 24'd1;
        din_i = 8'h55; din_valid_i = 1'b1;
        @(negedge clk_i);
        check("t2_count1", 32'(fifo_count_o), 32'(1));
        din_i = 8'hAA;
        @(negedge clk_i);
        din_valid_i = 1'b0;
        check("t2_count2", 32'(fifo_count_o), 32'(2));
        @(negedge clk_i);
        check("t2_count_a", 32'(fifo_count_o), 32'(1));
        expect_frame("t2a", 8'h55, 8, -1, 2, 1, 1'b0);
        check("t2_count_b", 32'(fifo_count_o), 32'(0));
        expect_frame("t2b", 8'hAA, 8, -1, 2, 1, 1'b0);
        check("t2_busy_end", 32'(busy_o), 32'(0));

        // Fill with tx disabled, refuse 17th push, drain in order
        tx_en_i = 1'b0; stopbits_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din_i = 8'(8'h11 * i);
            din_valid_i = 1'b1;
            @(negedge clk_i);
        end
        check("t3_count16", 32'(fifo_count_o), 32'(16));
        check("t3_ready0",  32'(din_ready_o),  32'(0));
        check("t3_idle",    32'(busy_o),       32'(0));
        din_i = 8'hEE;
        @(negedge clk_i);
        check("t3_refused", 32'(fifo_count_o), 32'(16));
        tx_en_i = 1'b1;
        @(negedge clk_i);
        din_valid_i = 1'b0;
        check("t3_pop_no_push", 32'(fifo_count_o), 32'(15));
        for (int i = 0; i < 16; i++) begin
            expect_frame($sformatf("t3f%0d", i), 8'(8'h11 * i), 8, -1, 1, 1, 1'b0);
        end
        check("t3_busy_end",  32'(busy_o),       32'(0));
        check("t3_count_end", 32'(fifo_count_o), 32'(0));

        // DATA_BITS=7, even parity: bit 7 never appears on the line
        parity_i = 3'b010; stopbits_i = 1'b0; divisor_i = 24'd2;
        push7(8'hFF);
        wait_start("t4_start_ff", 1'b1);
        expect_frame("t4ff", 8'hFF, 7, 1, 1, 2, 1'b1);
        check("t4_busy_ff", 32'(busy7), 32'(0));
        push7(8'h80);
        wait_start("t4_start_80", 1'b1);
        expect_frame("t4_80", 8'h80, 7, 0, 1, 2, 1'b1);
        check("t4_busy_80", 32'(busy7), 32'(0));

        // Divisor 0 behaves as 1
        parity_i = 3'b000; divisor_i = 24'd0;
        push(8'h3A);
        wait_start("t5_start", 1'b0);
        expect_frame("t5", 8'h3A, 8, -1, 1, 1, 1'b0);
        check("t5_busy_end", 32'(busy_o), 32'(0));

        // Divisor change 4 -> 8 during a frame takes effect on the next frame
        divisor_i = 24'd4;
        push(8'h0F);
        push(8'hF0);
        wait_start("t6_start", 1'b0);
        divisor_i = 24'd8;
        expect_frame("t6a", 8'h0F, 8, -1, 1, 4, 1'b0);
        expect_frame("t6b", 8'hF0, 8, -1, 1, 8, 1'b0);
        check("t6_busy_end", 32'(busy_o), 32'(0));

        // Asynchronous reset in the middle of a data bit
        parity_i = 3'b001; divisor_i = 24'd4;
        push(8'h3A);
        push(8'h55);
        wait_start("t7_start", 1'b0);
        repeat (5) @(negedge clk_i);
        check("t7_pre_tx",    32'(tx_o),         32'(0));
        check("t7_pre_count", 32'(fifo_count_o), 32'(1));
        #2 rst_i = 1'b0;
        #1;
        check("t7_rst_tx",    32'(tx_o),         32'(1));
        check("t7_rst_count", 32'(fifo_count_o), 32'(0));
        check("t7_rst_busy",  32'(busy_o),       32'(0));
        check("t7_rst_ready", 32'(din_ready_o),  32'(1));
        @(negedge clk_i);
        rst_i = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
        end
        check("t7_quiet_after", 32'(lows), 32'(0));
        check("t7_count_after", 32'(fifo_count_o), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
